muxpga_fabric: RTL and testbench

//   Parametrised mux-based programmable logic fabric: NCELLS K-input LUT cells, each with
//   per-input source muxes over primary inputs and cell outputs, optional output flop.

---
 rtl/muxpga_fabric.sv | 146 ++++++++++++++
 tb/tb_muxpga_fabric.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muxpga_fabric.sv
// muxpga_fabric
//   Mux-based programmable logic fabric. NCELLS K-input LUT cells. Each LUT input
//   has a source mux that picks from the primary inputs or from the cell outputs.
//   Each cell has an optional output flop.
//
//   Configuration is loaded serially into a shadow register while the fabric keeps
//   running on the active configuration. A commit then copies the shadow into the
//   active configuration in a single cycle.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   ena         clock enable for the cell flops (the config logic ignores it)
//   fab_in      primary inputs [NIN]
//   fab_out     outputs of cells 0..NOUT-1
//   cfg_en      shift cfg_data into the shadow this cycle
//   cfg_data    serial config bit (the first bit sent ends at the shadow MSB)
//   cfg_commit  copy shadow -> active
//   cfg_full    at least CFGW bits have been shifted since the last commit/reset
//   cfg_err     sticky; set when a commit arrives without a full shadow
//   running     an active configuration has been committed
//
// Cell i field = active[i*CW +: CW]:
//   [2**K-1:0]   truth table, index = {in[K-1],...,in[0]}
//   next K*SELW  input selects, sel0 lowest
//   MSB          reg_en (1: output comes from the cell flop)
module muxpga_fabric #(
  parameter int NIN    = 8,
  parameter int NCELLS = 8,
  parameter int K      = 3,
  parameter int NOUT   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [NIN-1:0]  fab_in,
  output logic [NOUT-1:0] fab_out,
  input  logic            cfg_en,
  input  logic            cfg_data,
  input  logic            cfg_commit,
  output logic            cfg_full,
  output logic            cfg_err,
  output logic            running
);

  localparam int POOL = NIN + NCELLS;
  localparam int SELW = $clog2(POOL);
  localparam int TW   = 2 ** K;
  localparam int CW   = TW + K * SELW + 1;
  localparam int CFGW = NCELLS * CW;
  localparam int CNTW = $clog2(CFGW + 1);

  logic [CFGW-1:0]   shadow_r;
  logic [CFGW-1:0]   active_r;
  logic [CNTW-1:0]   count_r;
  logic [NCELLS-1:0] q_r;
  logic              cfg_err_r;
  logic              running_r;

  logic [NCELLS-1:0] lut_s;
  logic [NCELLS-1:0] out_s;
  logic              commit_ok_s;

  assign cfg_full    = (count_r == CNTW'(CFGW));
  assign commit_ok_s = cfg_commit & cfg_full;
  assign cfg_err     = cfg_err_r;
  assign running     = running_r;
  assign fab_out     = out_s[NOUT-1:0];

  // LUT evaluation, cells resolved in ascending order.
  // A cell reads the live output of lower-numbered cells only. A cell that reads
  // itself or a higher-numbered cell gets that cell's flop. This rules out
  // combinational loops by construction.
  always_comb begin
    logic [SELW-1:0] sel;
    logic [K-1:0]    idx;
    logic [TW-1:0]   tbl;
    logic            in_bit;
    lut_s = '0;
    out_s = '0;
    for (int i = 0; i < NCELLS; i++) begin
      idx = '0;
      tbl = active_r[i*CW +: TW];
      for (int k = 0; k < K; k++) begin
        sel    = active_r[i*CW + TW + k*SELW +: SELW];
        in_bit = 1'b0;
        // Out-of-pool select codes match nothing and read 0.
        for (int p = 0; p < NIN; p++) begin
          in_bit = (sel == SELW'(p)) ? fab_in[p] : in_bit;
        end
        for (int j = 0; j < NCELLS; j++) begin
          in_bit = (sel == SELW'(NIN + j)) ? ((j < i) ? out_s[j] : q_r[j]) : in_bit;
        end
        idx[k] = in_bit;
      end
      lut_s[i] = tbl[idx];
      out_s[i] = active_r[i*CW + CW - 1] ? q_r[i] : lut_s[i];
    end
  end

  // Config path: shadow shift register, bit counter, active copy, status flags.
  // On a successful commit, any shift requested in the same cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r  <= '0;
      active_r  <= '0;
      count_r   <= '0;
      cfg_err_r <= 1'b0;
      running_r <= 1'b0;
    end else begin
      if (commit_ok_s) begin
        active_r  <= shadow_r;
        count_r   <= '0;
        running_r <= 1'b1;
      end else if (cfg_en) begin
        shadow_r <= {shadow_r[CFGW-2:0], cfg_data};
        if (!cfg_full) begin
          count_r <= count_r + CNTW'(1);
        end else begin
          count_r <= count_r;
        end
      end else begin
        count_r <= count_r;
      end
      if (cfg_commit) begin
        cfg_err_r <= ~cfg_full;
      end else begin
        cfg_err_r <= cfg_err_r;
      end
    end
  end

  // Cell flops. A commit clears them so the new configuration starts from a known state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (commit_ok_s) begin
      q_r <= '0;
    end else if (running_r && ena) begin
      q_r <= lut_s;
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: tb/tb_muxpga_fabric.sv
module tb_muxpga_fabric;

  localparam int CFGW = 168;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] fab_in;
  logic [7:0] fab_out;
  logic       cfg_en;
  logic       cfg_data;
  logic       cfg_commit;
  logic       cfg_full;
  logic       cfg_err;
  logic       running;

  muxpga_fabric dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .fab_in     (fab_in),
    .fab_out    (fab_out),
    .cfg_en     (cfg_en),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_full   (cfg_full),
    .cfg_err    (cfg_err),
    .running    (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       full;
    logic       err;
    logic       run;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [CFGW-1:0] cfg2;
  logic [CFGW-1:0] cfg3;
  logic            tq;

  // Monitor: compare every expectation queued this cycle against the DUT at the falling edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({fab_out, cfg_full, cfg_err, running} !== {e.out, e.full, e.err, e.run}) begin
        errors++;
        $display("FAIL %s: got out=%h full=%b err=%b run=%b, want out=%h full=%b err=%b run=%b",
                 e.name, fab_out, cfg_full, cfg_err, running, e.out, e.full, e.err, e.run);
      end
    end
  end

  // Watchdog: flag a hung simulation
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string n, input logic [7:0] o, input logic f,
                           input logic er, input logic r);
    exp_t e;
    e.name = n;
    e.out  = o;
    e.full = f;
    e.err  = er;
    e.run  = r;
    sb.push_back(e);
  endtask

  task automatic shift_range(input logic [CFGW-1:0] v, input int hi, input int lo);
    for (int b = hi; b >= lo; b--) begin
      cfg_en   = 1'b1;
      cfg_data = v[b];
      step();
    end
    cfg_en = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b0;
    fab_in     = 8'h00;
    cfg_en     = 1'b0;
    cfg_data   = 1'b0;
    cfg_commit = 1'b0;

    // cell0 = in0 & in1
    cfg2           = '0;
    cfg2[7:0]      = 8'h88;
    cfg2[12 +: 4]  = 4'd1;
    // cell1 = ~q1, registered (toggle)
    cfg3           = '0;
    cfg3[21 +: 8]  = 8'h55;
    cfg3[29 +: 4]  = 4'd9;
    cfg3[41]       = 1'b1;

    // 1: reset
    step();
    checks++;
    if ({fab_out, cfg_full, cfg_err, running} !== 11'b0) begin
      errors++;
      $display("FAIL reset_state_direct: got out=%h full=%b err=%b run=%b, want all 0",
               fab_out, cfg_full, cfg_err, running);
    end
    expect_st("reset_hold", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    expect_st("reset_release", 8'h00, 1'b0, 1'b0, 1'b0);
    step();

    // 2: combinational AND cell
    shift_range(cfg2, CFGW-1, 0);
    expect_st("full_before_commit", 8'h00, 1'b1, 1'b0, 1'b0);
    commit();
    for (int c = 0; c < 4; c++) begin
      fab_in = 8'(c);
      expect_st("and_cell", (c == 3) ? 8'h01 : 8'h00, 1'b0, 1'b0, 1'b1);
      step();
    end

    // 3: registered toggle cell
    fab_in = 8'h00;
    shift_range(cfg3, CFGW-1, 0);
    commit();
    expect_st("toggle_after_commit", 8'h00, 1'b0, 1'b0, 1'b1);
    ena = 1'b1;
    step();
    expect_st("toggle_1", 8'h02, 1'b0, 1'b0, 1'b1);
    step();
    expect_st("toggle_2", 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    expect_st("toggle_3", 8'h02, 1'b0, 1'b0, 1'b1);
    ena = 1'b0;
    step();
    expect_st("hold_1", 8'h02, 1'b0, 1'b0, 1'b1);
    step();
    expect_st("hold_2", 8'h02, 1'b0, 1'b0, 1'b1);

    // 5: shift a new config while the toggle keeps running, then commit
    fab_in = 8'h03;
    ena    = 1'b1;
    tq     = 1'b1;
    for (int b = CFGW-1; b >= 0; b--) begin
      cfg_en   = 1'b1;
      cfg_data = cfg2[b];
      expect_st("toggle_during_shift", {6'b0, tq, 1'b0}, 1'b0, 1'b0, 1'b1);
      step();
      tq = ~tq;
    end
    cfg_en = 1'b0;
    expect_st("full_while_running", {6'b0, tq, 1'b0}, 1'b1, 1'b0, 1'b1);
    commit();
    expect_st("new_config_live", 8'h01, 1'b0, 1'b0, 1'b1);

    // 4: early commit flags an error and changes nothing
    shift_range(cfg3, CFGW-1, 68);
    expect_st("partial_100", 8'h01, 1'b0, 1'b0, 1'b1);
    commit();
    expect_st("early_commit_err", 8'h01, 1'b0, 1'b1, 1'b1);
    shift_range(cfg3, 67, 0);
    expect_st("full_after_168", 8'h01, 1'b1, 1'b1, 1'b1);
    ena = 1'b0;
    commit();
    expect_st("commit_clears_err", 8'h00, 1'b0, 1'b0, 1'b1);
    ena = 1'b1;
    step();
    expect_st("toggle_after_recommit", 8'h02, 1'b0, 1'b0, 1'b1);

    // 6: reset in the middle of a load discards it
    ena = 1'b0;
    shift_range(cfg2, CFGW-1, CFGW-50);
    rst_n = 1'b0;
    expect_st("mid_shift_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    shift_range(cfg2, CFGW-1, 1);
    expect_st("after_167_bits", 8'h00, 1'b0, 1'b0, 1'b0);
    shift_range(cfg2, 0, 0);
    expect_st("after_168_bits", 8'h00, 1'b1, 1'b0, 1'b0);

    // commit together with a shift: the pre-shift shadow is committed and the count restarts
    cfg_en     = 1'b1;
    cfg_data   = 1'b1;
    cfg_commit = 1'b1;
    step();
    cfg_en     = 1'b0;
    cfg_commit = 1'b0;
    expect_st("commit_with_shift", 8'h01, 1'b0, 1'b0, 1'b1);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
